// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 responder: FSM state encoding,
// distance/time constants and the distance-to-echo-width helpers.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF
  } state_t;

  localparam int unsigned US_PER_CM   = 58;
  localparam int unsigned DIST_MIN_CM = 2;
  localparam int unsigned DIST_MAX_CM = 400;

  // Limit the emulated target to the range a real sensor can report.
  function automatic logic [8:0] clamp_dist(input logic [8:0] d);
    if (d < 9'(DIST_MIN_CM)) begin
      return 9'(DIST_MIN_CM);
    end else if (d > 9'(DIST_MAX_CM)) begin
      return 9'(DIST_MAX_CM);
    end
    return d;
  endfunction

  // Echo high time in microseconds for a (clamped) distance.
  function automatic logic [15:0] echo_width_us(input logic [8:0] d);
    return 16'(clamp_dist(d)) * 16'(US_PER_CM);
  endfunction

endpackage

// File: rtl/hcsr04_responder_us_tick.sv
// Restartable 1 us prescaler: tick is high for one clk cycle out of every
// CYCLES_PER_US; restart forces the phase back to zero so that the first
// tick after a restart lands exactly CYCLES_PER_US cycles later.
module us_tick
  import hcsr04_pkg::*;
#(
  parameter int unsigned CYCLES_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_US - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tick = (count_q == LAST);

  // Next phase: wrap on tick, return to zero on restart.
  always_comb begin
    count_d = count_q + 1'b1;
    if (restart || tick) begin
      count_d = '0;
    end
  end

  // Phase register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/hcsr04_responder.sv
// HC-SR04 ultrasonic sensor emulator: measures the trigger pulse, waits the
// burst time, then returns an echo pulse whose width encodes dist_cm.
// Optional feature macro: HCSR04_RESP_JITTER_EN adds 0..3 us of LFSR-driven
// jitter to every echo width.
module hcsr04_responder
  import hcsr04_pkg::*;
#(
  parameter int unsigned CYCLES_PER_US = 50,
  parameter int unsigned TRIG_MIN_US   = 10,
  parameter int unsigned BURST_US      = 200,
  parameter int unsigned TIMEOUT_US    = 38000,
  parameter int unsigned HOLDOFF_US    = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [8:0]  dist_cm,
  input  logic        no_object,
  output logic        echo,
  output logic        busy,
  output logic [15:0] pulse_count,
  output logic        trig_err
);

  localparam logic [16:0] TRIG_MIN_W = 17'(TRIG_MIN_US);
  localparam logic [15:0] BURST_LAST = 16'(BURST_US - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_US - 1);
  localparam logic [15:0] TIMEOUT_W  = 16'(TIMEOUT_US);

  logic        sync1_q, sync2_q, prev_q;
  logic        trig_rise, trig_fall;
  state_t      state_q, state_d;
  logic [15:0] us_cnt_q, us_cnt_d;
  logic [15:0] echo_us_q, echo_us_d;
  logic [15:0] pulse_count_q, pulse_count_d;
  logic        echo_q, echo_d;
  logic        trig_err_q, trig_err_d;
  logic        restart, tick;
  logic        width_ok, accept, echo_done;
  logic [15:0] jitter_us;

  us_tick #(.CYCLES_PER_US(CYCLES_PER_US)) u_us_tick (
    .clk    (clk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  // Edges are taken on the synchronized trigger only; prev_q tracks it
  // continuously so a level that is already high never looks like an edge.
  assign trig_rise = sync2_q & ~prev_q;
  assign trig_fall = ~sync2_q & prev_q;

  // The tick in the falling-edge cycle still belongs to the high time.
  assign width_ok  = ({1'b0, us_cnt_q} + 17'(tick)) >= TRIG_MIN_W;
  assign accept    = (state_q == TRIG_HI) && trig_fall && width_ok;
  assign echo_done = ({1'b0, us_cnt_q} + 17'd1) == {1'b0, echo_us_q};

`ifdef HCSR04_RESP_JITTER_EN
  logic [7:0] lfsr_q, lfsr_d;

  assign jitter_us = 16'(lfsr_q[1:0]);

  // Advance the jitter source once per accepted trigger (x^8+x^6+x^5+x^4+1).
  always_comb begin
    lfsr_d = lfsr_q;
    if (accept) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // Jitter LFSR register, reseeded on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign jitter_us = 16'd0;
`endif

  // Next-state, microsecond counter and latched echo width.
  always_comb begin
    state_d       = state_q;
    us_cnt_d      = us_cnt_q;
    echo_us_d     = echo_us_q;
    pulse_count_d = pulse_count_q;
    trig_err_d    = 1'b0;
    if (tick && (us_cnt_q != 16'hFFFF)) begin
      us_cnt_d = us_cnt_q + 16'd1;
    end
    case (state_q)
      IDLE: begin
        if (trig_rise) state_d = TRIG_HI;
      end
      TRIG_HI: begin
        if (accept) begin
          state_d       = BURST;
          pulse_count_d = pulse_count_q + 16'd1;
          echo_us_d     = (no_object ? TIMEOUT_W : echo_width_us(dist_cm)) + jitter_us;
        end else if (trig_fall) begin
          state_d    = IDLE;
          trig_err_d = 1'b1;
        end
      end
      BURST: begin
        if (tick && (us_cnt_q == BURST_LAST)) state_d = ECHO;
      end
      ECHO: begin
        if (tick && echo_done) state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (tick && (us_cnt_q == HOLD_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Every transition restarts the prescaler and the us count so each
    // state's duration is measured from its own first cycle.
    restart = (state_d != state_q);
    if (restart) begin
      us_cnt_d = '0;
    end
    echo_d = (state_d == ECHO);
  end

  // State, synchronizer and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      prev_q        <= 1'b0;
      state_q       <= IDLE;
      us_cnt_q      <= '0;
      echo_us_q     <= '0;
      pulse_count_q <= '0;
      echo_q        <= 1'b0;
      trig_err_q    <= 1'b0;
    end else begin
      sync1_q       <= trigger;
      sync2_q       <= sync1_q;
      prev_q        <= sync2_q;
      state_q       <= state_d;
      us_cnt_q      <= us_cnt_d;
      echo_us_q     <= echo_us_d;
      pulse_count_q <= pulse_count_d;
      echo_q        <= echo_d;
      trig_err_q    <= trig_err_d;
    end
  end

  assign echo        = echo_q;
  assign busy        = (state_q != IDLE);
  assign pulse_count = pulse_count_q;
  assign trig_err    = trig_err_q;

endmodule
